fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control unit. It holds the PC and issues word fetches to instruction memory over a valid/ready request channel with in-order responses. Fetched words go into a small FIFO and are presented to decode as a full instruction plus the pre-split `op`, `funct3` and `funct7_5` fields the control unit consumes. A taken branch or jump (`redirect`, driven from the control unit's `PCSrc` path) flushes the FIFO, kills in-flight fetches and restarts at the target.

---
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC, request issue, in-flight PC queue and instruction FIFO feeding decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7_5
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] FULL = (CW+1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fpc_q [DEPTH];
    logic [31:0]   fpc_d [DEPTH];
    logic [31:0]   fword_q [DEPTH];
    logic [31:0]   fword_d [DEPTH];
    logic [31:0]   qpc_q [DEPTH];
    logic [31:0]   qpc_d [DEPTH];
    logic [AW-1:0] frd_q, frd_d, fwr_q, fwr_d, qrd_q, qrd_d, qwr_q, qwr_d;
    logic [CW-1:0] fcnt_q, fcnt_d, infl_q, infl_d, kill_q, kill_d;
    logic          req_fire, rsp_fire, push, pop;
    assign imem_req_valid = rst_n && !redirect && ({1'b0, fcnt_q} + {1'b0, infl_q} < FULL);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = fcnt_q != '0;
    assign instr          = instr_valid ? fword_q[frd_q] : NOP;
    assign instr_pc       = instr_valid ? fpc_q[frd_q] : 32'h0;
    assign op             = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7_5       = instr[30];
    always_comb begin
        req_fire = imem_req_valid && imem_req_ready;
        rsp_fire = imem_rsp_valid && infl_q != '0;
        push     = rsp_fire && kill_q == '0 && !redirect;
        pop      = instr_valid && instr_ready;
        pc_d     = redirect ? (redirect_target & ~32'h3) : req_fire ? pc_q + 32'd4 : pc_q;
        qpc_d    = qpc_q;
        if (req_fire) qpc_d[qwr_q] = pc_q;
        qwr_d    = qwr_q + AW'(req_fire);
        // killed responses still retire their queued issue PC to keep order
        qrd_d    = qrd_q + AW'(rsp_fire);
        infl_d   = infl_q + CW'(req_fire) - CW'(rsp_fire);
        kill_d   = redirect ? infl_d : kill_q - CW'(rsp_fire && kill_q != '0);
        fpc_d    = fpc_q;
        fword_d  = fword_q;
        if (push) begin
            fpc_d[fwr_q]   = qpc_q[qrd_q];
            fword_d[fwr_q] = imem_rsp_data;
        end
        fwr_d    = redirect ? '0 : fwr_q + AW'(push);
        frd_d    = redirect ? '0 : frd_q + AW'(pop);
        fcnt_d   = redirect ? '0 : fcnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            frd_q  <= '0;
            fwr_q  <= '0;
            qrd_q  <= '0;
            qwr_q  <= '0;
            fcnt_q <= '0;
            infl_q <= '0;
            kill_q <= '0;
        end else begin
            pc_q   <= pc_d;
            frd_q  <= frd_d;
            fwr_q  <= fwr_d;
            qrd_q  <= qrd_d;
            qwr_q  <= qwr_d;
            fcnt_q <= fcnt_d;
            infl_q <= infl_d;
            kill_q <= kill_d;
        end
    end
    always_ff @(posedge clk) begin
        fpc_q   <= fpc_d;
        fword_q <= fword_d;
        qpc_q   <= qpc_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with a latency-programmable memory model driving fetch_unit.
module tb_fetch_unit;
    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect, instr_valid, instr_ready, funct7_5;
    logic [31:0] redirect_target, instr, instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .op(op), .funct3(funct3), .funct7_5(funct7_5)
    );
    int n_chk = 0, n_fail = 0, cyc = 0, lat = 1;
    logic        mready = 1;
    logic [31:0] dmask = 0;
    logic [31:0] pend_dat[$], exp_pc[$], exp_dat[$];
    int          pend_due[$];
    logic        obs_reqv, obs_req, obs_valid, obs_pop, obs_rsp;
    logic [31:0] obs_addr, obs_pc;
    int          obs_cyc;
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic step(input logic redir, input logic [31:0] tgt);
        logic [31:0] epc, ed;
        redirect = redir;
        redirect_target = tgt;
        imem_req_ready = mready;
        imem_rsp_valid = 0;
        imem_rsp_data = 0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data = pend_dat[0];
        end
        #1;
        obs_cyc = cyc;
        obs_reqv = imem_req_valid;
        obs_addr = imem_req_addr;
        obs_req = imem_req_valid && mready;
        obs_valid = instr_valid;
        obs_pop = instr_valid && instr_ready;
        obs_pc = instr_pc;
        obs_rsp = imem_rsp_valid;
        if (obs_pop) begin
            n_chk++;
            if (exp_pc.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty got pc=%h instr=%h exp=none", instr_pc, instr);
            end else begin
                epc = exp_pc.pop_front();
                ed = exp_dat.pop_front();
                if (instr_pc !== epc || instr !== ed) begin
                    n_fail++;
                    $display("FAIL sb_word got pc=%h instr=%h exp pc=%h instr=%h", instr_pc, instr, epc, ed);
                end
                n_chk++;
                if ({op, funct3, funct7_5} !== {ed[6:0], ed[14:12], ed[30]}) begin
                    n_fail++;
                    $display("FAIL sb_fields got %h/%h/%b exp %h/%h/%b", op, funct3, funct7_5, ed[6:0], ed[14:12], ed[30]);
                end
            end
        end
        @(posedge clk);
        if (obs_rsp) begin
            void'(pend_dat.pop_front());
            void'(pend_due.pop_front());
        end
        if (redir) begin
            exp_pc.delete();
            exp_dat.delete();
        end
        if (obs_req) begin
            pend_dat.push_back(obs_addr ^ dmask);
            pend_due.push_back(cyc + lat);
            exp_pc.push_back(obs_addr);
            exp_dat.push_back(obs_addr ^ dmask);
        end
        @(negedge clk);
        cyc++;
        redirect = 0;
    endtask
    task automatic do_reset();
        rst_n = 0;
        redirect = 0;
        imem_rsp_valid = 0;
        pend_dat.delete();
        pend_due.delete();
        exp_pc.delete();
        exp_dat.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        cyc = 1;
    endtask
    task automatic test_reset();
        rst_n = 1;
        #2;
        rst_n = 0;
        #1;
        n_chk++;
        if ({instr_valid, imem_req_valid, instr, instr_pc} !== {1'b0, 1'b0, 32'h13, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_out got v=%b rv=%b i=%h pc=%h exp 0 0 00000013 0", instr_valid, imem_req_valid, instr, instr_pc);
        end
        n_chk++;
        if ({op, funct3, funct7_5} !== {7'h13, 3'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_fields got %h/%h/%b exp 13/0/0", op, funct3, funct7_5);
        end
        do_reset();
        step(0, 0);
        n_chk++;
        if (!obs_reqv || obs_addr !== 32'hBFC0_0000) begin
            n_fail++;
            $display("FAIL first_req got v=%b addr=%h exp 1 bfc00000", obs_reqv, obs_addr);
        end
    endtask
    task automatic test_stream();
        int first = -1, pops = 0, reqs = 0;
        lat = 1; mready = 1; instr_ready = 1; dmask = 0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(0, 0);
            if (obs_valid && first < 0) first = obs_cyc;
            if (obs_pop && obs_cyc >= 3 && obs_cyc < 13) pops++;
            if (obs_req) reqs++;
        end
        n_chk++;
        if (first !== 3) begin
            n_fail++;
            $display("FAIL first_valid got cycle=%0d exp 3", first);
        end
        n_chk++;
        if (pops !== 10 || reqs !== 14) begin
            n_fail++;
            $display("FAIL throughput got pops=%0d reqs=%0d exp 10 14", pops, reqs);
        end
    endtask
    task automatic test_backpressure();
        int reqs = 0, pops = 0;
        logic [31:0] resume = 0;
        lat = 1; mready = 1; instr_ready = 0; dmask = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, 0);
            if (obs_req) reqs++;
        end
        n_chk++;
        if (reqs !== 4 || obs_reqv !== 0 || obs_valid !== 1) begin
            n_fail++;
            $display("FAIL full_block got reqs=%0d rv=%b v=%b exp 4 0 1", reqs, obs_reqv, obs_valid);
        end
        instr_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0);
            if (obs_pop) pops++;
            if (obs_req && resume == 0) resume = obs_addr;
        end
        n_chk++;
        if (pops !== 4 || resume !== 32'hBFC0_0010) begin
            n_fail++;
            $display("FAIL drain got pops=%0d resume=%h exp 4 bfc00010", pops, resume);
        end
        repeat (4) step(0, 0);
    endtask
    task automatic test_redirect_kill();
        logic [31:0] fpc = 0;
        logic seen = 0;
        lat = 3; mready = 1; instr_ready = 1; dmask = 0;
        do_reset();
        repeat (3) step(0, 0);
        step(1, 32'h100);
        n_chk++;
        if (obs_reqv !== 0 || obs_rsp !== 1) begin
            n_fail++;
            $display("FAIL kill_redir_cycle got rv=%b rsp=%b exp 0 1", obs_reqv, obs_rsp);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 0);
            if (obs_pop && !seen) begin
                seen = 1;
                fpc = obs_pc;
            end
        end
        n_chk++;
        if (!seen || fpc !== 32'h100) begin
            n_fail++;
            $display("FAIL kill_first_pc got seen=%b pc=%h exp 1 00000100", seen, fpc);
        end
    endtask
    task automatic test_redirect_pop();
        lat = 1; mready = 1; instr_ready = 1; dmask = 0;
        do_reset();
        repeat (6) step(0, 0);
        step(1, 32'h203);
        n_chk++;
        if (obs_pop !== 1 || obs_rsp !== 1 || obs_reqv !== 0) begin
            n_fail++;
            $display("FAIL redir_pop_cycle got pop=%b rsp=%b rv=%b exp 1 1 0", obs_pop, obs_rsp, obs_reqv);
        end
        step(0, 0);
        n_chk++;
        if (obs_reqv !== 1 || obs_addr !== 32'h200 || obs_valid !== 0) begin
            n_fail++;
            $display("FAIL redir_target_req got rv=%b addr=%h v=%b exp 1 00000200 0", obs_reqv, obs_addr, obs_valid);
        end
        step(0, 0);
        n_chk++;
        if (obs_valid !== 0) begin
            n_fail++;
            $display("FAIL redir_r2_valid got %b exp 0", obs_valid);
        end
        step(0, 0);
        n_chk++;
        if (obs_valid !== 1 || obs_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_r3 got v=%b pc=%h exp 1 00000200", obs_valid, obs_pc);
        end
        repeat (3) step(0, 0);
    endtask
    task automatic test_stall();
        logic [31:0] a0;
        int bad = 0;
        lat = 1; mready = 1; instr_ready = 1; dmask = 32'h4000_4063;
        do_reset();
        repeat (5) step(0, 0);
        mready = 0;
        step(0, 0);
        a0 = obs_addr;
        for (int i = 0; i < 4; i++) begin
            step(0, 0);
            if (obs_reqv !== 1 || obs_addr !== a0) bad++;
        end
        n_chk++;
        if (bad !== 0 || a0 !== 32'hBFC0_0014) begin
            n_fail++;
            $display("FAIL stall_hold got bad=%0d addr=%h exp 0 bfc00014", bad, a0);
        end
        mready = 1;
        step(0, 0);
        n_chk++;
        if (obs_req !== 1 || obs_addr !== a0) begin
            n_fail++;
            $display("FAIL stall_accept got req=%b addr=%h exp 1 %h", obs_req, obs_addr, a0);
        end
        step(0, 0);
        n_chk++;
        if (obs_addr !== a0 + 32'd4) begin
            n_fail++;
            $display("FAIL stall_next got addr=%h exp %h", obs_addr, a0 + 32'd4);
        end
        repeat (5) step(0, 0);
    endtask
    task automatic test_mid_reset();
        logic seen = 0;
        logic [31:0] fpc = 0;
        lat = 1; mready = 1; instr_ready = 0; dmask = 0;
        do_reset();
        repeat (2) step(0, 0);
        mready = 0;
        repeat (2) step(0, 0);
        n_chk++;
        if (obs_valid !== 1) begin
            n_fail++;
            $display("FAIL mid_pre_valid got %b exp 1", obs_valid);
        end
        rst_n = 0;
        #1;
        n_chk++;
        if (instr_valid !== 0 || instr !== 32'h13 || instr_pc !== 0) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b i=%h pc=%h exp 0 00000013 0", instr_valid, instr, instr_pc);
        end
        mready = 1;
        instr_ready = 1;
        do_reset();
        step(0, 0);
        n_chk++;
        if (obs_reqv !== 1 || obs_addr !== 32'hBFC0_0000) begin
            n_fail++;
            $display("FAIL mid_restart got rv=%b addr=%h exp 1 bfc00000", obs_reqv, obs_addr);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0);
            if (obs_pop && !seen) begin
                seen = 1;
                fpc = obs_pc;
            end
        end
        n_chk++;
        if (!seen || fpc !== 32'hBFC0_0000) begin
            n_fail++;
            $display("FAIL mid_first_pc got seen=%b pc=%h exp 1 bfc00000", seen, fpc);
        end
    endtask
    initial begin
        rst_n = 1; redirect = 0; redirect_target = 0; instr_ready = 1;
        imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_kill();
        test_redirect_pop();
        test_stall();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
